// File: rtl/mod5_pkg.sv
// Shared types and the mod-5 residue step used by the
// serial transmitter and the receiver-side checker.
package mod5_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    typedef logic [2:0] residue_t;

    localparam int MOD = 5;

    // Unreachable encodings 5..7 fall back to 0.
    function automatic residue_t mod5_next(residue_t r, logic b);
        residue_t n;
        case (r)
            3'd0:    n = b ? 3'd1 : 3'd0;
            3'd1:    n = b ? 3'd3 : 3'd2;
            3'd2:    n = b ? 3'd0 : 3'd4;
            3'd3:    n = b ? 3'd2 : 3'd1;
            3'd4:    n = b ? 3'd4 : 3'd3;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mod5_serial_tx_if.sv
// Parallel word handshake into the serial transmitter.
interface mod5_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/mod5_residue_step.sv
// Registered running residue (mod 5) of the emitted bit
// stream, with the matching divisible-by-5 flag.
module mod5_residue_step
    import mod5_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     en,
    input  logic     bit_in,
    output residue_t residue,
    output logic     exp_div5
);

    residue_t nxt;

    always_comb begin
        nxt = residue;
        if (clear)
            nxt = '0;
        else if (en)
            nxt = mod5_next(residue, bit_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            residue  <= '0;
            exp_div5 <= 1'b1;
        end else begin
            residue  <= nxt;
            exp_div5 <= (nxt == '0);
        end
    end

endmodule

// File: rtl/mod5_serial_tx.sv
// MSB-first serial stimulus source with a golden running
// mod-5 residue, aligned with a Moore-style detector.
module mod5_serial_tx
    import mod5_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mod5_serial_tx_if.slave  bus,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_end,
    output residue_t         residue,
    output logic             exp_div5,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP  = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [3:0]       gap_cnt;
    logic             accept;
    logic             step;

    always_comb begin
        state_nxt    = state;
        x            = 1'b0;
        x_valid      = 1'b0;
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        bus.in_ready = 1'b0;
        busy         = 1'b1;
        accept       = 1'b0;
        step         = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                accept       = bus.in_valid;
                if (bus.in_valid)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                x           = shreg[WIDTH-1];
                x_valid     = 1'b1;
                frame_start = (cnt == CNT_TOP);
                frame_end   = (cnt == '0);
                step        = !abort;
                if (abort)
                    state_nxt = IDLE;
                else if (cnt == '0)
                    state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (abort || gap_cnt == GAP_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shreg   <= bus.in_data;
                cnt     <= CNT_TOP;
                gap_cnt <= '0;
            end else if (state != IDLE && abort) begin
                shreg   <= '0;
                cnt     <= '0;
                gap_cnt <= '0;
            end else if (state == SHIFT) begin
                shreg <= shreg << 1;
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // A non-continuous stream restarts its residue with each word.
    mod5_residue_step u_res (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept && !CONTINUOUS),
        .en       (step),
        .bit_in   (shreg[WIDTH-1]),
        .residue  (residue),
        .exp_div5 (exp_div5)
    );

endmodule

// File: tb/tb_mod5_serial_tx.sv
// Bench for mod5_serial_tx: directed tables, corner sequences
// and a randomized run against a word-level reference model.
module tb_mod5_serial_tx;
    import mod5_pkg::*;

    logic clk;
    logic reset;
    logic abort_ab;
    logic abort_c;

    mod5_serial_tx_if #(.WIDTH(8)) ia ();
    mod5_serial_tx_if #(.WIDTH(8)) ib ();
    mod5_serial_tx_if #(.WIDTH(1)) ic ();

    logic xa, xva, fsa, fea, eda, busya;
    logic xb, xvb, fsb, feb, edb, busyb;
    logic xc, xvc, fsc, fec, edc, busyc;
    residue_t resa, resb, resc;

    mod5_serial_tx #(.WIDTH(8), .GAP_CYCLES(1), .CONTINUOUS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(ia), .abort(abort_ab),
        .x(xa), .x_valid(xva), .frame_start(fsa), .frame_end(fea),
        .residue(resa), .exp_div5(eda), .busy(busya)
    );

    mod5_serial_tx #(.WIDTH(8), .GAP_CYCLES(1), .CONTINUOUS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ib), .abort(abort_ab),
        .x(xb), .x_valid(xvb), .frame_start(fsb), .frame_end(feb),
        .residue(resb), .exp_div5(edb), .busy(busyb)
    );

    mod5_serial_tx #(.WIDTH(1), .GAP_CYCLES(0), .CONTINUOUS(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bus(ic), .abort(abort_c),
        .x(xc), .x_valid(xvc), .frame_start(fsc), .frame_end(fec),
        .residue(resc), .exp_div5(edc), .busy(busyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       x;
        logic       fs;
        logic       fe;
        logic [2:0] res;
        logic       ed;
    } vec_t;

    vec_t t1[8];
    int   t6[5];

    // Word-level reference model: pending bit count, gap count, value mod 5.
    int         mn[2];
    int         mg[2];
    int         macc[2];
    logic [7:0] mw[2];
    bit         mcont[2];

    task automatic model_step(input int d, input logic v,
                              input logic [7:0] data, input logic ab);
        if (mn[d] > 0 || mg[d] > 0) begin
            if (ab) begin
                mn[d] = 0;
                mg[d] = 0;
            end else if (mn[d] > 0) begin
                macc[d] = (2 * macc[d] + int'(mw[d][mn[d]-1])) % MOD;
                mn[d]--;
                if (mn[d] == 0) mg[d] = 1;
            end else begin
                mg[d]--;
            end
        end else if (v) begin
            mw[d] = data;
            mn[d] = 8;
            if (!mcont[d]) macc[d] = 0;
        end
    endtask

    task automatic model_cmp(input int d, input logic x, input logic xv,
                             input logic fs, input logic fe, input residue_t r,
                             input logic ed, input logic bz, input logic rdy);
        int ex;
        ex = (mn[d] > 0) ? int'(mw[d][mn[d]-1]) : 0;
        chk($sformatf("rnd%0d.x", d), int'(x), ex);
        chk($sformatf("rnd%0d.x_valid", d), int'(xv), int'(mn[d] > 0));
        chk($sformatf("rnd%0d.frame_start", d), int'(fs), int'(mn[d] == 8));
        chk($sformatf("rnd%0d.frame_end", d), int'(fe), int'(mn[d] == 1));
        chk($sformatf("rnd%0d.residue", d), int'(r), macc[d]);
        chk($sformatf("rnd%0d.exp_div5", d), int'(ed), int'(macc[d] == 0));
        chk($sformatf("rnd%0d.busy", d), int'(bz), int'(mn[d] > 0 || mg[d] > 0));
        chk($sformatf("rnd%0d.in_ready", d), int'(rdy), int'(mn[d] == 0 && mg[d] == 0));
    endtask

    task automatic idle_inputs();
        ia.in_valid = 1'b0; ia.in_data = '0;
        ib.in_valid = 1'b0; ib.in_data = '0;
        ic.in_valid = 1'b0; ic.in_data = '0;
        abort_ab = 1'b0;
        abort_c  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic v;
        logic [7:0] dat;
        logic ab;

        t1[0] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
        t1[1] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
        t1[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
        t1[3] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
        t1[4] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0};
        t1[5] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
        t1[6] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        t1[7] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
        t6 = '{1, 3, 2, 0, 1};

        reset = 1'b1;
        idle_inputs();

        // Reset state
        @(negedge clk);
        chk("rst.in_ready", int'(ia.in_ready), 1);
        chk("rst.busy", int'(busya), 0);
        chk("rst.x_valid", int'(xva), 0);
        chk("rst.x", int'(xa), 0);
        chk("rst.frame_start", int'(fsa), 0);
        chk("rst.frame_end", int'(fea), 0);
        chk("rst.residue", int'(resa), 0);
        chk("rst.exp_div5", int'(eda), 1);
        chk("rst.c_busy", int'(busyc), 0);
        chk("rst.c_ready", int'(ic.in_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // Word 0x0A bit by bit
        do_reset();
        ia.in_valid = 1'b1;
        ia.in_data  = 8'h0A;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ia.in_valid = 1'b0;
            chk($sformatf("t1.x[%0d]", i), int'(xa), int'(t1[i].x));
            chk($sformatf("t1.x_valid[%0d]", i), int'(xva), 1);
            chk($sformatf("t1.frame_start[%0d]", i), int'(fsa), int'(t1[i].fs));
            chk($sformatf("t1.frame_end[%0d]", i), int'(fea), int'(t1[i].fe));
            if (i > 0) begin
                chk($sformatf("t1.residue[%0d]", i - 1), int'(resa), int'(t1[i-1].res));
                chk($sformatf("t1.exp_div5[%0d]", i - 1), int'(eda), int'(t1[i-1].ed));
            end
        end
        @(negedge clk);
        chk("t1.residue[7]", int'(resa), int'(t1[7].res));
        chk("t1.exp_div5[7]", int'(eda), int'(t1[7].ed));
        chk("t1.gap_busy", int'(busya), 1);
        chk("t1.gap_x_valid", int'(xva), 0);
        @(negedge clk);
        chk("t1.idle_busy", int'(busya), 0);
        chk("t1.idle_ready", int'(ia.in_ready), 1);

        // Two words with valid held high through the first frame
        do_reset();
        ia.in_valid = 1'b1; ia.in_data = 8'h0A;
        ib.in_valid = 1'b1; ib.in_data = 8'h0A;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                ia.in_data = 8'h07;
                ib.in_data = 8'h07;
            end
            chk($sformatf("bp.ready_a[%0d]", k), int'(ia.in_ready), 0);
            chk($sformatf("bp.ready_b[%0d]", k), int'(ib.in_ready), 0);
        end
        @(negedge clk);
        chk("bp.ready_idle", int'(ia.in_ready), 1);
        @(negedge clk);
        ia.in_valid = 1'b0;
        ib.in_valid = 1'b0;
        chk("bp.second_start", int'(fsa), 1);
        chk("bp.second_x_valid", int'(xva), 1);
        chk("bp.b_cleared", int'(resb), 0);
        repeat (8) @(negedge clk);
        chk("cont.residue_a", int'(resa), 2);
        chk("cont.exp_div5_a", int'(eda), 0);
        chk("noncont.residue_b", int'(resb), 2);
        chk("noncont.exp_div5_b", int'(edb), 0);

        // Abort on the 4th bit of 0xF0
        do_reset();
        ia.in_valid = 1'b1; ia.in_data = 8'hF0;
        @(negedge clk);
        ia.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort.pre_residue", int'(resa), 2);
        abort_ab = 1'b1;
        @(negedge clk);
        abort_ab = 1'b0;
        chk("abort.x_valid", int'(xva), 0);
        chk("abort.busy", int'(busya), 0);
        chk("abort.ready", int'(ia.in_ready), 1);
        chk("abort.residue", int'(resa), 2);

        // Asynchronous reset between edges mid-frame
        do_reset();
        ia.in_valid = 1'b1; ia.in_data = 8'hFF;
        @(negedge clk);
        ia.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("areset.pre_residue", int'(resa), 3);
        #2 reset = 1'b1;
        #1;
        chk("areset.x_valid", int'(xva), 0);
        chk("areset.x", int'(xa), 0);
        chk("areset.busy", int'(busya), 0);
        chk("areset.ready", int'(ia.in_ready), 1);
        chk("areset.residue", int'(resa), 0);
        chk("areset.exp_div5", int'(eda), 1);
        @(negedge clk);
        reset = 1'b0;
        ia.in_valid = 1'b1; ia.in_data = 8'h03;
        @(negedge clk);
        ia.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("areset.restart_residue", int'(resa), 3);

        // WIDTH=1, no gap: back-to-back single-bit words
        do_reset();
        ic.in_valid = 1'b1; ic.in_data = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("w1.x_valid[%0d]", k), int'(xvc), 1);
            chk($sformatf("w1.x[%0d]", k), int'(xc), 1);
            chk($sformatf("w1.start[%0d]", k), int'(fsc), 1);
            chk($sformatf("w1.end[%0d]", k), int'(fec), 1);
            @(negedge clk);
            if (k == 4) ic.in_valid = 1'b0;
            chk($sformatf("w1.residue[%0d]", k), int'(resc), t6[k]);
            chk($sformatf("w1.exp_div5[%0d]", k), int'(edc), int'(t6[k] == 0));
            chk($sformatf("w1.accept_gap[%0d]", k), int'(xvc), 0);
        end

        // Randomized run against the reference model
        do_reset();
        for (int d = 0; d < 2; d++) begin
            mn[d] = 0; mg[d] = 0; macc[d] = 0; mw[d] = '0;
        end
        mcont[0] = 1'b1;
        mcont[1] = 1'b0;
        for (int c = 0; c < 600; c++) begin
            model_cmp(0, xa, xva, fsa, fea, resa, eda, busya, ia.in_ready);
            model_cmp(1, xb, xvb, fsb, feb, resb, edb, busyb, ib.in_ready);
            v   = ($urandom_range(0, 3) != 0);
            dat = 8'($urandom);
            ab  = ($urandom_range(0, 19) == 0);
            ia.in_valid = v; ia.in_data = dat;
            ib.in_valid = v; ib.in_data = dat;
            abort_ab = ab;
            model_step(0, v, dat, ab);
            model_step(1, v, dat, ab);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
